watch_set_ctrl: RTL
===================

# watch_set_ctrl

Control unit for the watch datapath. It turns debounced mode/up/down button levels into the one-hot field-select levels and the single-cycle up/down pulses the watch time counters consume. It sequences the RUN → SET_HOUR → SET_MIN → SET_SEC → RUN mode cycle, auto-repeats held up/down buttons, returns to RUN after an inactivity timeout, and drives a blink enable for the field being edited. It sits between the button debouncers and the watch datapath.

## Interface
- REPEAT_DELAY, 50_000_000: clk cycles a button must stay held after its first pulse before auto-repeat starts (≥2).
- REPEAT_PERIOD, 10_000_000: clk cycles between auto-repeat pulses (≥2).
- TIMEOUT, 1_000_000_000: idle clk cycles in a SET state before the block returns to RUN (≥2).
- BLINK_HALF, 25_000_000: clk cycles per blink half-period (≥1).
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-low; asserted at 0.
- i_btn_mode  in  1  debounced mode button level, synchronous to clk.
- i_btn_up  in  1  debounced up button level.
- i_btn_down  in  1  debounced down button level.
- o_set_hour, o_set_min, o_set_sec  out  1 each  field select levels; at most one is high.
- o_up, o_down  out  1  increment/decrement pulses, one clk cycle wide.
- o_mode  out  2  state code: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- o_blink  out  1  display enable for the selected field.

## Operation
- **Edge detection.** Each button has a previous-sample register. A rise is the input sampled 1 with its previous sample 0.
- **FSM on mode rise.** RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
  - o_set_* are decoded from the state.
  - o_mode equals the state code.
- **Up/down outside SET.** In RUN, up/down activity is ignored. o_up and o_down stay 0 and the repeat counter is held at 0.
- **First pulse.** In a SET state, an up rise produces one o_up pulse. A down rise produces one o_down pulse.
- **Auto-repeat.**
  - While the same single button stays held, a further pulse is issued REPEAT_DELAY cycles after the first pulse.
  - After that, one pulse is issued every REPEAT_PERIOD cycles.
  - Releasing the button clears the repeat counter.
- **Up and down both high.** No pulses are issued and the repeat counter clears. When one button is released, the other does not start repeating until it sees a fresh rise.
- **Mode rise in the same cycle as an up/down rise.** The mode rise wins: the state advances and no pulse is issued. A button held across a state change needs a new rise before it pulses.
- **Timeout counter.**
  - Counts every cycle in a SET state where all three inputs are 0.
  - Clears on any input high and in RUN.
  - Reaching TIMEOUT−1 forces RUN on the next edge.
- **Blink.**
  - o_blink is 1 in RUN.
  - On entry to any SET state, o_blink is 1 and the blink counter is 0.
  - In a SET state, o_blink toggles every BLINK_HALF cycles.
  - Any up/down pulse reloads o_blink to 1 and the counter to 0, so the edited value is visible.
- **Counter widths.** Each counter is $clog2(its parameter) bits and saturates at its terminal value; none wraps.

## Timing
- **Reset.** While rst=0: state RUN, o_mode=0, o_set_*=0, o_up=o_down=0, o_blink=1, all counters 0, previous-sample registers 0.
- **Reset release with a button held.** The first sample after release is treated as a rise.
- **Registered outputs.** All outputs are registered. Let cycle n be the first cycle a rise is sampled:
  - o_up/o_down is high in cycle n+1 only.
  - o_mode/o_set_* take the new state from cycle n+1.
- **Repeat pulses.** Held button: pulses in cycles n+1, n+1+REPEAT_DELAY, then +REPEAT_PERIOD each.
- **Timeout.** If inputs are last high in cycle m, o_mode=0 from cycle m+TIMEOUT+1.
- **Pulse width.** o_up and o_down are never high in the same cycle and never longer than one cycle.
- **Reset mid-operation.** Returns to RUN immediately (asynchronous) and drops any pulse in flight.
- **Datapath interaction.** The datapath gives its own tick priority over up/down. A pulse coinciding with a carry tick is lost by design, and the operator repeats the press.

## Test plan
Parameters for all scenarios: REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT=50, BLINK_HALF=5.
- **Reset and mode cycle.** Hold rst=0, then release and give 4 mode rises 10 cycles apart → during reset all outputs at their reset values; o_mode steps 1,2,3,0 one cycle after each rise; exactly one o_set_* high in SET states.
- **Up in SET_MIN.** In SET_MIN, press up for 1 cycle → exactly one o_up pulse one cycle later. Press up in RUN → no pulse.
- **Auto-repeat.** In SET_HOUR, hold down 30 cycles from cycle n → o_down in cycles n+1, n+9, n+13, n+17, n+21, n+25, n+29; none after release.
- **Simultaneous presses.**
  - Up and down rise together, held 20 cycles → no pulses.
  - Mode and up rise in the same cycle → state advances, no o_up.
- **Timeout.** Enter SET_SEC, leave inputs idle → o_mode=0 exactly 51 cycles after the last high input. Any press at idle cycle 49 restarts the count.
- **Blink and reset mid-operation.**
  - In SET_HOUR idle → o_blink pattern 1×5, 0×5, repeating. An up pulse forces o_blink=1 and restarts the pattern.
  - rst=0 during a repeat hold → immediate RUN and o_down=0.

Source files
------------

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: converts debounced mode/up/down button levels into the
// field-select levels and single-cycle up/down pulses for the watch counters.
// Handles the mode cycle, auto-repeat of a held up/down button, return to
// RUN after an idle timeout, and a blink enable for the field being edited.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   i_btn_mode   debounced mode button level
//   i_btn_up     debounced up button level
//   i_btn_down   debounced down button level
//   o_set_hour   hour field selected (registered)
//   o_set_min    minute field selected (registered)
//   o_set_sec    second field selected (registered)
//   o_up         one-cycle increment pulse
//   o_down       one-cycle decrement pulse
//   o_mode       state code: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
//   o_blink      display enable for the selected field
//
// state       | meaning
// ------------+----------------------------------------------
// ST_RUN      | normal timekeeping, up/down ignored
// ST_SET_HOUR | editing hours
// ST_SET_MIN  | editing minutes
// ST_SET_SEC  | editing seconds
module watch_set_ctrl #(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int TIMEOUT       = 1_000_000_000,
    parameter int BLINK_HALF    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    output logic       o_set_hour,
    output logic       o_set_min,
    output logic       o_set_sec,
    output logic       o_up,
    output logic       o_down,
    output logic [1:0] o_mode,
    output logic       o_blink
);

    localparam int RD_W  = (REPEAT_DELAY  > 1) ? $clog2(REPEAT_DELAY)  : 1;
    localparam int RP_W  = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
    localparam int REP_W = (RD_W > RP_W) ? RD_W : RP_W;
    localparam int TO_W  = (TIMEOUT       > 1) ? $clog2(TIMEOUT)       : 1;
    localparam int BL_W  = (BLINK_HALF    > 1) ? $clog2(BLINK_HALF)    : 1;

    localparam logic [REP_W-1:0] RD_TC = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RP_TC = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_TC = TO_W'(TIMEOUT - 1);
    localparam logic [BL_W-1:0]  BL_TC = BL_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    // Which button currently owns the auto-repeat; NONE means a fresh rise
    // is required before any further pulse.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_UP   = 2'd1,
        SRC_DOWN = 2'd2
    } src_t;

    state_t            state;
    state_t            state_nxt;
    src_t              rep_src;
    logic              rep_phase;     // 0: waiting first repeat, 1: periodic
    logic [REP_W-1:0]  rep_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [BL_W-1:0]   bl_cnt;
    logic              mode_q, up_q, down_q;

    logic              mode_rise, up_rise, down_rise, any_in, rep_hold;
    logic [REP_W-1:0]  rep_tc;

    assign mode_rise = i_btn_mode & ~mode_q;
    assign up_rise   = i_btn_up   & ~up_q;
    assign down_rise = i_btn_down & ~down_q;
    assign any_in    = i_btn_mode | i_btn_up | i_btn_down;
    assign rep_hold  = ((rep_src == SRC_UP)   && i_btn_up) ||
                       ((rep_src == SRC_DOWN) && i_btn_down);
    assign rep_tc    = rep_phase ? RP_TC : RD_TC;
    assign o_mode    = state;

    always_comb begin
        state_nxt = state;
        if (mode_rise) begin
            case (state)
                ST_RUN:      state_nxt = ST_SET_HOUR;
                ST_SET_HOUR: state_nxt = ST_SET_MIN;
                ST_SET_MIN:  state_nxt = ST_SET_SEC;
                default:     state_nxt = ST_RUN;
            endcase
        end else if (state != ST_RUN && !any_in && to_cnt == TO_TC) begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RUN;
            rep_src    <= SRC_NONE;
            rep_phase  <= 1'b0;
            rep_cnt    <= '0;
            to_cnt     <= '0;
            bl_cnt     <= '0;
            mode_q     <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            o_set_hour <= 1'b0;
            o_set_min  <= 1'b0;
            o_set_sec  <= 1'b0;
            o_up       <= 1'b0;
            o_down     <= 1'b0;
            o_blink    <= 1'b1;
        end else begin
            mode_q     <= i_btn_mode;
            up_q       <= i_btn_up;
            down_q     <= i_btn_down;
            state      <= state_nxt;
            o_set_hour <= (state_nxt == ST_SET_HOUR);
            o_set_min  <= (state_nxt == ST_SET_MIN);
            o_set_sec  <= (state_nxt == ST_SET_SEC);
            o_up       <= 1'b0;
            o_down     <= 1'b0;

            // Any state change (mode rise or timeout) and all of RUN restart
            // every counter; a mode rise therefore also swallows a coincident
            // up/down rise.
            if (state_nxt != state || state == ST_RUN) begin
                rep_src   <= SRC_NONE;
                rep_phase <= 1'b0;
                rep_cnt   <= '0;
                to_cnt    <= '0;
                bl_cnt    <= '0;
                o_blink   <= 1'b1;
            end else begin
                to_cnt <= any_in ? '0 : to_cnt + 1'b1;

                if (bl_cnt == BL_TC) begin
                    o_blink <= ~o_blink;
                    bl_cnt  <= '0;
                end else begin
                    bl_cnt <= bl_cnt + 1'b1;
                end

                // Pulse branches below override the blink update so the
                // edited field is shown right after every pulse.
                if (i_btn_up && i_btn_down) begin
                    rep_src   <= SRC_NONE;
                    rep_phase <= 1'b0;
                    rep_cnt   <= '0;
                end else if (up_rise) begin
                    o_up      <= 1'b1;
                    rep_src   <= SRC_UP;
                    rep_phase <= 1'b0;
                    rep_cnt   <= '0;
                    o_blink   <= 1'b1;
                    bl_cnt    <= '0;
                end else if (down_rise) begin
                    o_down    <= 1'b1;
                    rep_src   <= SRC_DOWN;
                    rep_phase <= 1'b0;
                    rep_cnt   <= '0;
                    o_blink   <= 1'b1;
                    bl_cnt    <= '0;
                end else if (rep_hold) begin
                    if (rep_cnt == rep_tc) begin
                        o_up      <= (rep_src == SRC_UP);
                        o_down    <= (rep_src == SRC_DOWN);
                        rep_phase <= 1'b1;
                        rep_cnt   <= '0;
                        o_blink   <= 1'b1;
                        bl_cnt    <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end else begin
                    rep_src   <= SRC_NONE;
                    rep_phase <= 1'b0;
                    rep_cnt   <= '0;
                end
            end
        end
    end

endmodule
